instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  begins a load session; base  in  32  start byte address.
REQ-004 SHALL have ports: finish  in  1  ends the session after the current accept.
REQ-005 SHALL have ports: in_valid  in  1 and in_ready  out  1; request handshake.
REQ-006 SHALL have ports: kind  in  3  (0 R, 1 I, 2 S, 3 B, 4 LUI, 5 JAL, 6 LW, 7 JALR); func3  in  3; f7b5  in  1; rd, rs1, rs2  in  5 each; imm  in  32.
REQ-007 SHALL have ports: out_valid  out  1 and out_ready  in  1; instr  out  32; addr  out  32  byte address of instr.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse; err  out  1  sticky; words  out  16  count of emitted words.

Function
REQ-009 SHALL implement FSM IDLE, LOAD, DRAIN, DONE.
REQ-010 IDLE: start=1 SHALL load the address counter with base, clear words and err, and move to LOAD; start SHALL be ignored in all other states.
REQ-011 in_ready SHALL equal (state==LOAD) && (!out_valid || out_ready).
REQ-012 A request is accepted when in_valid && in_ready; a legal request SHALL appear on instr/addr with out_valid=1 on the next cycle (latency 1).
REQ-013 out_valid, instr and addr SHALL hold stable until out_valid && out_ready; output handshake and a new accept in the same cycle SHALL give back-to-back words with no bubble.
REQ-014 The address counter SHALL advance by 4 per legal accept, wrapping modulo 2^32; words SHALL increment per output handshake and saturate at 0xFFFF.
REQ-015 R encoding SHALL be {0,f7b5,00000, rs2, rs1, func3, rd, 0110011}.
REQ-016 I encoding SHALL be {imm[11:0], rs1, func3, rd, 0010011}; for func3 001/101, bits 31:25 SHALL be {0,f7b5,00000} and bits 24:20 SHALL be imm[4:0].
REQ-017 LW encoding SHALL be {imm[11:0], rs1, 010, rd, 0000011}; JALR encoding SHALL be {imm[11:0], rs1, 000, rd, 1100111}; func3 input is ignored for both.
REQ-018 S encoding SHALL be {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
REQ-019 B encoding SHALL be {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 1100011}, with func3 000 beq, 001 bne, 010 blt, 011 bge, matching the pipeline decoder.
REQ-020 LUI encoding SHALL be {imm[31:12], rd, 0110111}; JAL encoding SHALL be {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-021 Upper immediate bits not encoded SHALL be ignored, with no range check.
REQ-022 A request is illegal when it is B with func3[2]=1, B with imm[0]=1, or JAL with imm[0]=1.
REQ-023 An illegal request SHALL be accepted and dropped: no output word, no address advance, and err set to 1 until the next start or reset.
REQ-024 LOAD: finish=1 SHALL move to DRAIN; a request accepted in the same cycle SHALL be processed normally.
REQ-025 DRAIN: in_ready SHALL be 0; the FSM SHALL move to DONE on the cycle where out_valid is 0 or an output handshake occurs.
REQ-026 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE and drive in_ready, out_valid, done and err to 0, and instr, addr, words and the counter to 0.
REQ-028 Reset mid-session SHALL discard any pending word; no output handshake SHALL complete while rst=0.

Verification
REQ-029 start, base=0x100; I rd=1 rs1=0 func3=000 imm=5 -> instr=0x00500093, addr=0x100.
REQ-030 R rd=3 rs1=1 rs2=2 func3=000 f7b5=1 -> 0x402081B3; B rs1=1 rs2=2 func3=000 imm=8 -> 0x00208463; LUI rd=5 imm=0x12345000 -> 0x123452B7; JAL rd=1 imm=0x800 -> 0x001000EF.
REQ-031 Three back-to-back requests with out_ready=0 for 3 cycles -> in_ready=0 while a word is held; instr stable; words emitted in order at addresses 0x100, 0x104, 0x108 after release.
REQ-032 B with imm=3 between two legal requests -> err=1, no word emitted, the next legal word gets the next sequential address.
REQ-033 finish together with a final accept and out_ready=1 -> that word is emitted, done pulses once, then IDLE; words equals the emitted count.
REQ-034 rst=0 asserted while out_valid=1 in LOAD -> all outputs 0 immediately; a later start with base=0 resumes at addr=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder with a load-session controller.
// Encodes RV32 requests into 32-bit words, tags each with a sequential byte
// address and hands them out over a one-deep valid/ready output register.
//
// state | meaning
// IDLE  | waiting for start; start loads base and clears words/err
// LOAD  | accepting requests; finish ends the session
// DRAIN | no new accepts; wait for the held word (if any) to leave
// DONE  | one-cycle done pulse, then back to IDLE
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  kind,
    input  logic [2:0]  func3,
    input  logic        f7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [31:0] addr,
    output logic        done,
    output logic        err,
    output logic [15:0] words
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;
    logic [15:0] words_q, words_d;

    logic [31:0] enc;
    logic        illegal;
    logic        accept;
    logic        out_hs;

    // Encode the current request and flag the forms that cannot be encoded
    // (odd branch/jump offsets, branch func3 outside beq/bne/blt/bge).
    always_comb begin
        enc     = 32'h0;
        illegal = 1'b0;
        case (kind)
            3'd0: enc = {1'b0, f7b5, 5'b0, rs2, rs1, func3, rd, OP_R};
            3'd1: begin
                if (func3 == 3'b001 || func3 == 3'b101)
                    enc = {1'b0, f7b5, 5'b0, imm[4:0], rs1, func3, rd, OP_I};
                else
                    enc = {imm[11:0], rs1, func3, rd, OP_I};
            end
            3'd2: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_S};
            3'd3: begin
                enc     = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], OP_B};
                illegal = func3[2] | imm[0];
            end
            3'd4: enc = {imm[31:12], rd, OP_LUI};
            3'd5: begin
                enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                illegal = imm[0];
            end
            3'd6: enc = {imm[11:0], rs1, 3'b010, rd, OP_LW};
            default: enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        endcase
    end

    // Session FSM, output register and counters; an output handshake and a
    // new accept in the same cycle reload the register with no bubble.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        words_d     = words_q;

        in_ready = (state_q == S_LOAD) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        out_hs   = out_valid_q && out_ready;

        if (out_hs) begin
            out_valid_d = 1'b0;
            if (words_q != 16'hFFFF)
                words_d = words_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = base;
                    words_d = 16'd0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        instr_d     = enc;
                        addr_d      = cnt_q;
                        cnt_d       = cnt_q + 32'd4;
                        out_valid_d = 1'b1;
                    end
                end
                if (finish)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'h0;
            instr_q     <= 32'h0;
            addr_q      <= 32'h0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= 16'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign addr      = addr_q;
    assign err       = err_q;
    assign words     = words_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random sessions.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, start, finish, in_valid, f7b5, out_ready;
    logic [31:0] base, imm;
    logic [2:0]  kind, func3;
    logic [4:0]  rd, rs1, rs2;
    logic        in_ready, out_valid, done, err;
    logic [31:0] instr, addr;
    logic [15:0] words;

    instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .func3(func3),
        .f7b5(f7b5), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
        .done(done), .err(err), .words(words)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] instr; logic [31:0] addr; } word_t;

    localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

    int          n_checks = 0;
    int          n_errors = 0;
    word_t       exp_q[$];
    word_t       log_q[$];
    int          m_phase = P_IDLE;
    logic [31:0] m_addr = 0;
    logic [15:0] m_words = 0;
    logic        m_err = 0;
    bit          rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement written out as shifts of the spec's bit ranges.
    function automatic logic [31:0] ref_enc(input int unsigned k, f3, f7, d, s1, s2, im);
        int unsigned w;
        case (k)
            0: w = (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h33;
            1: if (f3 == 1 || f3 == 5)
                   w = (f7 << 30) | ((im & 'h1f) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h13;
               else
                   w = ((im & 'hfff) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h13;
            2: w = (((im >> 5) & 'h7f) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12)
                   | ((im & 'h1f) << 7) | 'h23;
            3: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 'h3f) << 25) | (s2 << 20)
                   | (s1 << 15) | (f3 << 12) | (((im >> 1) & 'hf) << 8)
                   | (((im >> 11) & 1) << 7) | 'h63;
            4: w = (im & 'hfffff000) | (d << 7) | 'h37;
            5: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 'h3ff) << 21)
                   | (((im >> 11) & 1) << 20) | (((im >> 12) & 'hff) << 12) | (d << 7) | 'h6f;
            6: w = ((im & 'hfff) << 20) | (s1 << 15) | (2 << 12) | (d << 7) | 'h03;
            default: w = ((im & 'hfff) << 20) | (s1 << 15) | (d << 7) | 'h67;
        endcase
        return w;
    endfunction

    function automatic bit ref_illegal(input int unsigned k, f3, im);
        return (k == 3 && (f3 >= 4 || im % 2 == 1)) || (k == 5 && im % 2 == 1);
    endfunction

    // Reference model: checks what the DUT shows now, then advances over the coming edge.
    always @(negedge clk) begin
        bit exp_ov, exp_ir;
        if (!rst) begin
            exp_q.delete();
            m_phase = P_IDLE; m_addr = 0; m_words = 0; m_err = 0;
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_in_ready", {31'b0, in_ready}, 0);
            chk("rst_done", {31'b0, done}, 0);
            chk("rst_err", {31'b0, err}, 0);
            chk("rst_instr", instr, 0);
            chk("rst_addr", addr, 0);
            chk("rst_words", {16'b0, words}, 0);
        end else begin
            exp_ov = exp_q.size() != 0;
            exp_ir = (m_phase == P_LOAD) && (!exp_ov || out_ready);
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
            if (exp_ov) begin
                chk("instr", instr, exp_q[0].instr);
                chk("addr", addr, exp_q[0].addr);
            end
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            chk("done", {31'b0, done}, {31'b0, m_phase == P_DONE});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("words", {16'b0, words}, {16'b0, m_words});
            if (exp_ov && out_ready) begin
                log_q.push_back('{instr, addr});
                void'(exp_q.pop_front());
                if (m_words != 16'hFFFF) m_words++;
            end
            case (m_phase)
                P_IDLE: if (start) begin
                    m_addr = base; m_words = 0; m_err = 0; m_phase = P_LOAD;
                end
                P_LOAD: begin
                    if (in_valid && exp_ir) begin
                        if (ref_illegal(kind, func3, imm)) m_err = 1;
                        else begin
                            exp_q.push_back('{ref_enc(kind, func3, f7b5, rd, rs1, rs2, imm), m_addr});
                            m_addr += 4;
                        end
                    end
                    if (finish) m_phase = P_DRAIN;
                end
                P_DRAIN: if (!exp_ov || out_ready) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Random backpressure, applied after the stimulus thread has driven.
    always begin
        @(posedge clk); #2;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1; base = b; tick(); start = 0;
    endtask

    task automatic send(input int k, f3, f7, d, s1, s2, input logic [31:0] im, input bit fin);
        int n = 0;
        bit acc = 0;
        in_valid = 1; kind = 3'(k); func3 = 3'(f3); f7b5 = 1'(f7);
        rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im; finish = fin;
        while (!acc && n < 100) begin
            @(negedge clk); acc = in_ready;
            tick(); n++;
        end
        in_valid = 0; finish = 0;
        chk("send_accepted", {31'b0, acc}, 1);
    endtask

    task automatic fin_cycle();
        finish = 1; tick(); finish = 0;
    endtask

    task automatic wait_done(output int pulses);
        bit found = 0;
        int n = 0;
        pulses = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done) begin found = 1; pulses++; end
            tick(); n++;
            if (found && n > 4) break;
        end
        chk("done_seen", {31'b0, found}, 1);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] ei, input logic [31:0] ea);
        n_checks++;
        if (idx >= log_q.size()) begin
            n_errors++;
            $display("FAIL %s: word %0d missing, got %0d words", nm, idx, log_q.size());
        end else begin
            n_checks--;
            chk({nm, "_instr"}, log_q[idx].instr, ei);
            chk({nm, "_addr"}, log_q[idx].addr, ea);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, pulses;
        rst = 0; start = 0; base = 0; finish = 0; in_valid = 0; kind = 0; func3 = 0;
        f7b5 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0; out_ready = 1;

        chk("ref_I", ref_enc(1, 0, 0, 1, 0, 0, 5), 32'h00500093);
        chk("ref_R", ref_enc(0, 0, 1, 3, 1, 2, 0), 32'h402081B3);
        chk("ref_B", ref_enc(3, 0, 0, 0, 1, 2, 8), 32'h00208463);
        chk("ref_LUI", ref_enc(4, 0, 0, 5, 0, 0, 32'h12345000), 32'h123452B7);
        chk("ref_JAL", ref_enc(5, 0, 0, 1, 0, 0, 32'h800), 32'h001000EF);
        chk("ref_ill_B", {31'b0, ref_illegal(3, 0, 3)}, 1);

        repeat (3) tick();
        rst = 1;
        tick();

        // Reference encodings through the DUT
        l0 = log_q.size();
        do_start(32'h100);
        send(1, 0, 0, 1, 0, 0, 5, 0);
        send(0, 0, 1, 3, 1, 2, 0, 0);
        send(3, 0, 0, 0, 1, 2, 8, 0);
        send(4, 0, 0, 5, 0, 0, 32'h12345000, 0);
        send(5, 0, 0, 1, 0, 0, 32'h800, 0);
        fin_cycle();
        wait_done(pulses);
        chk_log("vec_I", l0, 32'h00500093, 32'h100);
        chk_log("vec_R", l0 + 1, 32'h402081B3, 32'h104);
        chk_log("vec_B", l0 + 2, 32'h00208463, 32'h108);
        chk_log("vec_LUI", l0 + 3, 32'h123452B7, 32'h10C);
        chk_log("vec_JAL", l0 + 4, 32'h001000EF, 32'h110);
        chk("vec_words", {16'b0, words}, 5);

        // Back-to-back requests under backpressure
        l0 = log_q.size();
        do_start(32'h100);
        out_ready = 0;
        fork
            begin
                send(1, 0, 0, 1, 0, 0, 1, 0);
                send(1, 0, 0, 2, 0, 0, 2, 0);
                send(1, 0, 0, 3, 0, 0, 3, 0);
            end
            begin
                repeat (2) tick();
                @(negedge clk);
                chk("hold_in_ready", {31'b0, in_ready}, 0);
                chk("hold_instr", instr, 32'h00100093);
                tick();
                out_ready = 1;
            end
        join
        fin_cycle();
        wait_done(pulses);
        chk_log("b2b0", l0, 32'h00100093, 32'h100);
        chk_log("b2b1", l0 + 1, 32'h00200113, 32'h104);
        chk_log("b2b2", l0 + 2, 32'h00300193, 32'h108);
        chk("b2b_words", {16'b0, words}, 3);

        // Illegal request between legal ones
        l0 = log_q.size();
        do_start(32'h200);
        send(1, 0, 0, 1, 0, 0, 7, 0);
        send(3, 0, 0, 0, 1, 2, 3, 0);
        send(1, 0, 0, 2, 0, 0, 9, 0);
        fin_cycle();
        wait_done(pulses);
        chk("ill_err", {31'b0, err}, 1);
        chk("ill_count", log_q.size() - l0, 2);
        chk_log("ill0", l0, 32'h00700093, 32'h200);
        chk_log("ill1", l0 + 1, 32'h00900113, 32'h204);

        // Finish together with the last accept
        l0 = log_q.size();
        do_start(32'h300);
        send(1, 0, 0, 1, 0, 0, 1, 0);
        send(1, 0, 0, 2, 0, 0, 2, 1);
        wait_done(pulses);
        chk("fin_pulses", pulses, 1);
        chk("fin_words", {16'b0, words}, 2);
        chk("fin_err", {31'b0, err}, 0);
        chk_log("fin1", l0 + 1, 32'h00200113, 32'h304);

        // Reset while a word is held
        do_start(32'h400);
        out_ready = 0;
        send(1, 0, 0, 1, 0, 0, 1, 0);
        chk("prerst_valid", {31'b0, out_valid}, 1);
        rst = 0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 0);
        chk("arst_instr", instr, 0);
        chk("arst_addr", addr, 0);
        chk("arst_words", {16'b0, words}, 0);
        repeat (2) tick();
        rst = 1; out_ready = 1;
        tick();
        l0 = log_q.size();
        do_start(32'h0);
        send(6, 0, 0, 4, 2, 0, 16, 0);
        fin_cycle();
        wait_done(pulses);
        chk_log("rst_resume", l0, 32'h01012203, 32'h0);

        // Random sessions
        for (int s = 0; s < 6; s++) begin
            rand_ready = 1;
            do_start((s == 2) ? 32'hFFFF_FFF4 : $urandom);
            for (int r = 0; r < 15; r++) begin
                repeat ($urandom_range(0, 2)) tick();
                send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom, 0);
            end
            tick();
            rand_ready = 0;
            out_ready = 1;
            if ($urandom_range(0, 1) == 1)
                send(1, 0, 0, 1, 0, 0, $urandom, 1);
            else
                fin_cycle();
            wait_done(pulses);
            chk("rand_pulses", pulses, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
